// File: rtl/add_sched_pkg.sv
// rtl/add_sched_pkg.sv - shared defaults, widths and response type for the adder scheduler
package add_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int LAT_DEF   = 1;
  localparam int ID_W      = $clog2(NREQ_DEF);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [WIDTH_DEF:0] sum;
  } rsp_t;

  // One slot per adder stage plus the operand register plus one for a same-cycle pop.
  function automatic int depth_of(input int lat);
    return lat + 2;
  endfunction

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/add_sched_if.sv
// rtl/add_sched_if.sv - requester, adder and response signals of the adder scheduler
interface add_sched_if
  import add_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = id_width(NREQ)
);

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][WIDTH-1:0]  req_a;
  logic [NREQ-1:0][WIDTH-1:0]  req_b;
  logic [NREQ-1:0]             req_ready;

  logic [WIDTH-1:0]            add_a;
  logic [WIDTH-1:0]            add_b;
  logic [WIDTH:0]              add_sum;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [WIDTH:0]              rsp_sum;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );

endinterface

// File: rtl/add_rsp_fifo.sv
// rtl/add_rsp_fifo.sv - first-word-fall-through FIFO with registered storage and occupancy count
module add_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DW-1:0]                wr_data,
  input  logic                         rd_en,
  output logic [DW-1:0]                rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is still safe when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_rd) rd_ptr <= bump(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/add_sched.sv
// rtl/add_sched.sv - round-robin scheduler sharing one registered adder between requesters,
// returning tagged results through a credit-protected response FIFO
module add_sched
  import add_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  add_sched_if.slave  bus
);

  localparam int IDW   = id_width(NREQ);
  localparam int DEPTH = depth_of(LAT);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int RW    = IDW + WIDTH + 1;

  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          grant_id;
  logic [IDW-1:0]          scan_idx;
  logic [NREQ-1:0]         grant;
  logic                    found;
  logic [CW-1:0]           credits;
  logic                    has_room;
  logic                    accept;
  logic                    pop;
  logic [LAT:0]            pipe_v;
  logic [LAT:0][IDW-1:0]   pipe_id;
  logic [RW-1:0]           fifo_rd;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    unused_fifo;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_id        = scan_idx;
      end
    end
  end

  assign pop      = bus.rsp_valid && bus.rsp_ready;
  // A pop this cycle frees its credit immediately, which keeps full throughput at DEPTH.
  assign has_room = (credits < CW'(DEPTH)) || pop;
  assign bus.req_ready = grant & {NREQ{has_room}};
  assign accept   = |(bus.req_valid & bus.req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      credits   <= '0;
      bus.add_a <= '0;
      bus.add_b <= '0;
      pipe_v    <= '0;
      pipe_id   <= '0;
    end else begin
      pipe_v  <= {pipe_v[LAT-1:0], accept};
      pipe_id <= {pipe_id[LAT-1:0], grant_id};
      if (accept) begin
        bus.add_a <= bus.req_a[grant_id];
        bus.add_b <= bus.req_b[grant_id];
        rr_ptr    <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
      end
      case ({accept, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase
    end
  end

  // The tag leaves the pipe in the same cycle its sum is valid on add_sum.
  add_rsp_fifo #(
    .DEPTH (DEPTH),
    .DW    (RW)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pipe_v[LAT]),
    .wr_data ({pipe_id[LAT], bus.add_sum}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign unused_fifo   = ^{fifo_count, fifo_full};
  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_id    = fifo_rd[RW-1 -: IDW];
  assign bus.rsp_sum   = fifo_rd[WIDTH:0];

endmodule

// File: tb/tb_add_sched.sv
// tb/tb_add_sched.sv - scoreboard bench for add_sched at LAT=1 plus a LAT=3 instance
module tb_add_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) b ();
  add_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) b3 ();

  add_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(1)) dut  (.clk(clk), .rst(rst), .bus(b));
  add_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  // external registered adders
  logic [WIDTH:0] s1;
  logic [WIDTH:0] s3 [3];
  always @(posedge clk) begin
    s1    <= {1'b0, b.add_a} + {1'b0, b.add_b};
    s3[0] <= {1'b0, b3.add_a} + {1'b0, b3.add_b};
    s3[1] <= s3[0];
    s3[2] <= s3[1];
  end
  assign b.add_sum  = s1;
  assign b3.add_sum = s3[2];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [WIDTH:0]  sum;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            e;
  int              acc_q[$];
  logic [NREQ-1:0] acc_mask = '0;
  int acc_total = 0, pop_total = 0, first_acc = -1, last_acc = -1;
  int acc3_cnt = 0, first_acc3 = -1, first_rsp3 = -1;
  int cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      acc_mask = '0;
    end else begin
      check("ready_onehot", {31'b0, $onehot0(b.req_ready)}, 1);
      acc_mask = b.req_valid & b.req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          e.id  = ID_W'(i);
          e.sum = {1'b0, b.req_a[i]} + {1'b0, b.req_b[i]};
          exp_q.push_back(e);
          acc_q.push_back(i);
          acc_total++;
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
        end
      end
      if (b.rsp_valid && b.rsp_ready) begin
        pop_total++;
        if (exp_q.size() == 0) begin
          check("rsp_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", b.rsp_id, e.id);
          check("rsp_sum", b.rsp_sum, e.sum);
        end
      end
      if (b3.req_valid[0] && b3.req_ready[0]) begin
        acc3_cnt++;
        if (first_acc3 < 0) first_acc3 = cyc;
      end
      if (b3.rsp_valid && first_rsp3 < 0) first_rsp3 = cyc;
    end
  end

  int              budget [NREQ] = '{default: 0};
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic rdy_next = 1'b0, rdy3_next = 1'b0, v3_next = 1'b0;

  // one clock: inputs change 1 time unit after posedge, return at negedge for sampling
  task automatic step();
    @(posedge clk);
    #1;
    b.rsp_ready     = rdy_next;
    b3.rsp_ready    = rdy3_next;
    b3.req_valid    = '0;
    b3.req_valid[0] = v3_next;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i]) budget[i]--;
      if (budget[i] > 0 && (acc_mask[i] || !b.req_valid[i])) begin
        b.req_a[i] = op_a[i];
        b.req_b[i] = op_b[i];
        op_a[i]    = WIDTH'($urandom);
        op_b[i]    = WIDTH'($urandom);
      end
      b.req_valid[i] = (budget[i] > 0);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    b.req_valid  = '0;
    b3.req_valid = '0;
    v3_next      = 1'b0;
    for (int i = 0; i < NREQ; i++) budget[i] = 0;
    acc_mask = '0;
    exp_q.delete();
    first_acc3 = -1;
    first_rsp3 = -1;
    acc3_cnt   = 0;
    #1;
    check("rst_rsp_valid", {31'b0, b.rsp_valid}, 0);
    check("rst_rsp_id", b.rsp_id, 0);
    check("rst_rsp_sum", b.rsp_sum, 0);
    check("rst_add_a", b.add_a, 0);
    check("rst_add_b", b.add_b, 0);
    check("rst_req_ready", b.req_ready, 0);
    check("rst_rsp_valid3", {31'b0, b3.rsp_valid}, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_next = 1'b1;
    while ((budget[0] + budget[1] + budget[2] + budget[3] > 0 || |b.req_valid ||
            exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check("drain_done", {31'b0, n < 200}, 1);
  endtask

  int exp13 [8] = '{1, 3, 1, 3, 0, 1, 2, 3};
  int n, lat, base, base_pop;

  initial begin
    b.req_valid  = '0;
    b.req_a      = '0;
    b.req_b      = '0;
    b.rsp_ready  = 1'b0;
    b3.req_valid = '0;
    b3.req_a     = '0;
    b3.req_b     = '0;
    b3.req_a[0]  = 8'h80;
    b3.req_b[0]  = 8'h90;
    b3.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = WIDTH'($urandom);
      op_b[i] = WIDTH'($urandom);
    end
    @(negedge clk);
    do_reset();

    // single request with carry out
    op_a[2]   = 8'hFF;
    op_b[2]   = 8'h01;
    budget[2] = 1;
    rdy_next  = 1'b1;
    step();
    check("single_grant", b.req_ready, 4'b0100);
    lat = 0;
    while (!b.rsp_valid && lat < 12) begin
      step();
      lat++;
    end
    check("single_latency", lat, 3);
    check("single_id", b.rsp_id, 2);
    check("single_sum", b.rsp_sum, 9'h100);
    drain();

    // all requesters continuously valid
    do_reset();
    acc_q.delete();
    first_acc = -1;
    for (int i = 0; i < NREQ; i++) budget[i] = 6;
    drain();
    check("rr_count", acc_q.size(), 24);
    for (int k = 0; k < 24; k++)
      check("rr_order", (k < acc_q.size()) ? acc_q[k] : 99, k % NREQ);
    check("rr_rate", last_acc - first_acc, 23);

    // stalled consumer: DEPTH accepts, then one accept per pop
    rdy_next = 1'b0;
    for (int i = 0; i < NREQ; i++) budget[i] = 3;
    base = acc_total;
    repeat (8) step();
    check("stall_accepts", acc_total - base, 3);
    check("stall_ready", b.req_ready, 0);
    check("stall_rsp_valid", {31'b0, b.rsp_valid}, 1);
    rdy_next = 1'b1;
    repeat (6) begin
      step();
      check("pop_accept", {31'b0, |(b.req_valid & b.req_ready)}, 1);
    end
    drain();
    check("no_lost", pop_total, acc_total);

    // sparse requesters and idle pointer hold
    do_reset();
    acc_q.delete();
    budget[1] = 2;
    budget[3] = 2;
    drain();
    repeat (4) step();
    for (int i = 0; i < NREQ; i++) budget[i] = 1;
    drain();
    check("sparse_count", acc_q.size(), 8);
    for (int k = 0; k < 8; k++)
      check("sparse_order", (k < acc_q.size()) ? acc_q[k] : 99, exp13[k]);

    // reset with one result buffered and two in flight
    rdy_next  = 1'b0;
    budget[0] = 1;
    budget[1] = 1;
    budget[2] = 1;
    base = acc_total;
    n = 0;
    while (!b.rsp_valid && n < 10) begin
      step();
      n++;
    end
    check("midrst_first_rsp", n, 4);
    check("midrst_accepts", acc_total - base, 3);
    do_reset();
    rdy_next = 1'b1;
    base_pop = pop_total;
    repeat (8) step();
    check("no_stale", pop_total - base_pop, 0);
    rdy_next = 1'b0;
    acc_q.delete();
    for (int i = 0; i < NREQ; i++) budget[i] = 2;
    base = acc_total;
    repeat (8) step();
    check("postrst_credits", acc_total - base, 3);
    check("postrst_first", (acc_q.size() > 0) ? acc_q[0] : 99, 0);
    drain();

    // LAT=3 instance
    do_reset();
    rdy3_next = 1'b0;
    v3_next   = 1'b1;
    repeat (12) step();
    check("lat3_accepts", acc3_cnt, 5);
    check("lat3_ready", b3.req_ready, 0);
    check("lat3_latency", first_rsp3 - first_acc3, 5);
    check("lat3_id", b3.rsp_id, 0);
    check("lat3_sum", b3.rsp_sum, 9'h110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    check("watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit reached");
  end

endmodule
